// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states
// and the in-flight scoreboard slot.
package hazard_pkg;

  // Slots store register indices at this fixed width so the struct is parameter-free.
  localparam int SB_RD_W = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RET   = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               is_load;
  } sb_slot_t;

  function automatic logic slot_hits(input sb_slot_t slot, input logic [SB_RD_W-1:0] rs);
    return slot.valid && slot.reg_write && (slot.rd != '0) && (slot.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot (EX/MEM/WB) record of in-flight destination registers, plus the
// youngest-wins forwarding select for each ID source operand.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  bubble,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output sb_slot_t              ex_slot,
  output fwd_sel_t              sel_a,
  output fwd_sel_t              sel_b
);

  sb_slot_t ex_q, mem_q, wb_q;
  sb_slot_t id_entry;

  function automatic fwd_sel_t pick(input logic vld, input logic use_rs,
                                    input logic [SB_RD_W-1:0] rs,
                                    input sb_slot_t ex_s, input sb_slot_t mem_s,
                                    input sb_slot_t wb_s);
    if (!vld || !use_rs)              return FWD_RF;
    else if (slot_hits(ex_s, rs))     return FWD_EXMEM;
    else if (slot_hits(mem_s, rs))    return FWD_MEMWB;
    else if (slot_hits(wb_s, rs))     return FWD_RET;
    else                              return FWD_RF;
  endfunction

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = id_valid;
    id_entry.rd        = SB_RD_W'(id_rd);
    id_entry.reg_write = id_reg_write;
    id_entry.is_load   = id_mem_read;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance) begin
      ex_q  <= bubble ? '0 : id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_slot = ex_q;
  assign sel_a   = pick(id_valid, id_use_rs1, SB_RD_W'(id_rs1), ex_q, mem_q, wb_q);
  assign sel_b   = pick(id_valid, id_use_rs2, SB_RD_W'(id_rs2), ex_q, mem_q, wb_q);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller top: stall/bubble/flush/freeze decode, registered forwarding
// selects, run/load-stall/mem-wait FSM and saturating debug counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  freeze,
  output logic [CNT_W-1:0]      ld_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      busy_cnt
);

  sb_slot_t  ex_slot;
  fwd_sel_t  sel_a, sel_b;
  fwd_sel_t  fwd_a_q, fwd_b_q;
  hz_state_t state_q, state_d;
  logic      post_rst_q;
  logic      load_use;
  logic      ev_busy, ev_flush, ev_ld;
  logic      advance, bubble;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .advance      (advance),
    .bubble       (bubble),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_slot      (ex_slot),
    .sel_a        (sel_a),
    .sel_b        (sel_b)
  );

  always_comb begin
    load_use = id_valid && ex_slot.valid && ex_slot.is_load && ex_slot.reg_write &&
               (ex_slot.rd != '0) &&
               ((id_use_rs1 && (SB_RD_W'(id_rs1) == ex_slot.rd)) ||
                (id_use_rs2 && (SB_RD_W'(id_rs2) == ex_slot.rd)));
  end

  // Hazard events are masked in the reset cycle and the one after it.
  always_comb begin
    ev_busy  = 1'b0;
    ev_flush = 1'b0;
    ev_ld    = 1'b0;
    if (!rst && !post_rst_q) begin
      if (mem_busy)             ev_busy  = 1'b1;
      else if (ex_branch_taken) ev_flush = 1'b1;
      else if (load_use)        ev_ld    = 1'b1;
    end
  end

  always_comb begin
    pc_stall    = ev_busy | ev_ld;
    ifid_stall  = ev_busy | ev_ld;
    idex_bubble = ev_flush | ev_ld;
    ifid_flush  = ev_flush;
    freeze      = ev_busy;
    advance     = !ev_busy;
    bubble      = ev_flush | ev_ld;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (ev_busy)    state_d = MEM_WAIT;
        else if (ev_ld) state_d = LD_STALL;
      end
      LD_STALL: state_d = ev_busy ? MEM_WAIT : RUN;
      MEM_WAIT: state_d = ev_busy ? MEM_WAIT : RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      post_rst_q   <= 1'b1;
      fwd_a_q      <= FWD_RF;
      fwd_b_q      <= FWD_RF;
      ld_stall_cnt <= '0;
      flush_cnt    <= '0;
      busy_cnt     <= '0;
    end else begin
      state_q    <= state_d;
      post_rst_q <= 1'b0;
      if (advance) begin
        fwd_a_q <= bubble ? FWD_RF : sel_a;
        fwd_b_q <= bubble ? FWD_RF : sel_b;
      end
      if (ev_ld && (ld_stall_cnt != '1))  ld_stall_cnt <= ld_stall_cnt + 1'b1;
      if (ev_flush && (flush_cnt != '1))  flush_cnt    <= flush_cnt + 1'b1;
      if (ev_busy && (busy_cnt != '1))    busy_cnt     <= busy_cnt + 1'b1;
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed vector bench for hazard_ctrl_unit: one table row per clock cycle,
// plus hand-written saturation and reset-during-freeze sequences.
module tb_hazard_ctrl_unit;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic          ex_branch_taken, mem_busy;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic          pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze;
  logic [CW-1:0] ld_stall_cnt, flush_cnt, busy_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .fwd_sel_a       (fwd_sel_a),
    .fwd_sel_b       (fwd_sel_b),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush),
    .freeze          (freeze),
    .ld_stall_cnt    (ld_stall_cnt),
    .flush_cnt       (flush_cnt),
    .busy_cnt        (busy_cnt)
  );

  // ctrl = {pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze}, checked before the edge;
  // fa/fb and the counters are checked just after the edge.
  typedef struct {
    logic          rst, vld;
    logic [RW-1:0] rs1, rs2;
    logic          u1, u2;
    logic [RW-1:0] rd;
    logic          rw, mr, br, busy;
    logic [4:0]    ctrl;
    logic [1:0]    fa, fb;
    logic [CW-1:0] ld, fl, bz;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input int rs1, input int rs2,
                              input logic u1, input logic u2, input int rd, input logic rw,
                              input logic mr, input logic br, input logic busy,
                              input logic [4:0] ctrl, input int fa, input int fb,
                              input int ld, input int fl, input int bz);
    vec_t t;
    t.rst = r;  t.vld = v;  t.rs1 = RW'(rs1);  t.rs2 = RW'(rs2);
    t.u1 = u1;  t.u2 = u2;  t.rd = RW'(rd);    t.rw = rw;  t.mr = mr;
    t.br = br;  t.busy = busy;  t.ctrl = ctrl;
    t.fa = 2'(fa);  t.fb = 2'(fb);
    t.ld = CW'(ld);  t.fl = CW'(fl);  t.bz = CW'(bz);
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst;  id_valid = t.vld;  id_rs1 = t.rs1;  id_rs2 = t.rs2;
    id_use_rs1 = t.u1;  id_use_rs2 = t.u2;  id_rd = t.rd;
    id_reg_write = t.rw;  id_mem_read = t.mr;
    ex_branch_taken = t.br;  mem_busy = t.busy;
    #1;
    check({tag, ".ctrl"}, 16'({pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze}), 16'(t.ctrl));
    @(posedge clk);
    #1;
    check({tag, ".fwd"}, 16'({fwd_sel_a, fwd_sel_b}), 16'({t.fa, t.fb}));
    check({tag, ".cnt"}, 16'({ld_stall_cnt, flush_cnt, busy_cnt}), 16'({t.ld, t.fl, t.bz}));
  endtask

  vec_t tbl[$];

  initial begin
    //                  rst v rs1 rs2 u1 u2 rd rw mr br bsy  ctrl     fa fb ld fl bz
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 5'b00000, 0, 0, 0, 0, 0)); // rst beats busy/branch
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 5, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0)); // add x5
    tbl.push_back(mk(0, 1, 5, 0,  1, 0, 1, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 0)); // reads x5 -> EX
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 6, 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 0)); // lw x6
    tbl.push_back(mk(0, 1, 1, 6,  1, 1, 2, 1, 0, 0, 0, 5'b11100, 0, 0, 1, 0, 0)); // load-use stall
    tbl.push_back(mk(0, 1, 1, 6,  1, 1, 2, 1, 0, 0, 0, 5'b00000, 3, 2, 1, 0, 0)); // x1 WB, x6 MEM
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 0)); // add x0
    tbl.push_back(mk(0, 1, 0, 2,  1, 1, 7, 1, 0, 0, 0, 5'b00000, 0, 2, 1, 0, 0)); // x0 never fwd
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 7, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 0)); // second x7 writer
    tbl.push_back(mk(0, 1, 7, 7,  1, 1, 3, 1, 0, 0, 0, 5'b00000, 1, 1, 1, 0, 0)); // EX beats MEM
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 0)); // empty ID
    tbl.push_back(mk(0, 1, 7, 3,  1, 1, 4, 1, 0, 0, 0, 5'b00000, 3, 2, 1, 0, 0)); // WB-only, MEM
    tbl.push_back(mk(0, 1, 4, 3,  0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 0)); // unused sources
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 8, 1, 1, 0, 0, 5'b00000, 0, 0, 1, 0, 0)); // lw x8
    tbl.push_back(mk(0, 1, 8, 0,  1, 0, 9, 1, 0, 1, 0, 5'b00110, 0, 0, 1, 1, 0)); // branch over load-use
    tbl.push_back(mk(0, 1, 8, 0,  1, 0, 10, 1, 1, 0, 0, 5'b00000, 2, 0, 1, 1, 0)); // lw x10, x8 MEM
    tbl.push_back(mk(0, 1, 10, 8, 1, 1, 11, 1, 0, 0, 1, 5'b11001, 2, 0, 1, 1, 1)); // busy hides load-use
    tbl.push_back(mk(0, 1, 10, 8, 1, 1, 11, 1, 0, 0, 1, 5'b11001, 2, 0, 1, 1, 2));
    tbl.push_back(mk(0, 1, 10, 8, 1, 1, 11, 1, 0, 0, 1, 5'b11001, 2, 0, 1, 1, 3));
    tbl.push_back(mk(0, 1, 10, 8, 1, 1, 11, 1, 0, 0, 0, 5'b11100, 0, 0, 2, 1, 3)); // stall after busy
    tbl.push_back(mk(0, 1, 10, 8, 1, 1, 11, 1, 0, 0, 0, 5'b00000, 2, 0, 2, 1, 3)); // x10 from MEM

    rst = 1'b1;  id_valid = 1'b0;  id_rs1 = '0;  id_rs2 = '0;  id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;  id_rd = '0;  id_reg_write = 1'b0;  id_mem_read = 1'b0;
    ex_branch_taken = 1'b0;  mem_busy = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // busy_cnt climbs from 3 and pins at 15; forwarding selects stay held.
    for (int i = 0; i < 14; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11001, 2, 0, 2, 1, (4 + i > 15) ? 15 : 4 + i),
            $sformatf("sat%0d", i));

    // Reset while in MEM_WAIT, then a quiet cycle despite busy/branch, then normal freeze.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0), "rst_mw");
    apply(mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 1, 1, 5'b00000, 0, 0, 0, 0, 0), "post_rst");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11001, 0, 0, 0, 0, 1), "busy_again");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1), "resume");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage core. It tracks the destination registers of in-flight instructions and drives the `sel` inputs of the two EX-stage 4:1 operand-forwarding multiplexers. It generates the stall, bubble and flush controls for the IF/ID and ID/EX pipeline registers, and keeps saturating hazard counters for debug.

## Interface

**Parameters**
- `REG_ADDR_W`, default 5: register-index width.
- `CNT_W`, default 16: width of each performance counter.

**Ports**
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs1`, `id_rs2` in `REG_ADDR_W`: source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads rs1/rs2.
- `id_rd` in `REG_ADDR_W`: destination register of the ID instruction.
- `id_reg_write` in 1: the ID instruction writes `id_rd`.
- `id_mem_read` in 1: the ID instruction is a load.
- `ex_branch_taken` in 1: redirect resolved in EX (branch or jump).
- `mem_busy` in 1: data memory not ready; the whole pipeline freezes.
- `fwd_sel_a`, `fwd_sel_b` out 2: operand-mux selects, registered, valid during EX.
- `pc_stall` out 1: hold PC.
- `ifid_stall` out 1: hold IF/ID.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `ifid_flush` out 1: clear IF/ID to NOP.
- `freeze` out 1: hold all pipeline registers.
- `ld_stall_cnt`, `flush_cnt`, `busy_cnt` out `CNT_W`: saturating event counters.

## Operation

**Select encoding** (operand mux inputs `in0`..`in3`):
- 00: register file.
- 01: EX/MEM ALU result.
- 10: MEM/WB writeback value.
- 11: retired-result register (WB+1 buffer), which covers regfile write/read in the same cycle.

**Scoreboard**
- Three slots: EX, MEM and WB. Each slot holds `{valid, rd, reg_write, is_load}`.
- On each advance cycle: EX ← ID fields (or an invalid entry if bubbling), MEM ← EX, WB ← MEM.

**Forwarding**
- Computed for the ID instruction against the current slots.
- Priority: EX slot → 01, else MEM slot → 10, else WB slot → 11, else 00.
- A slot matches only if it is valid, has `reg_write=1` and `rd!=0`, and its `rd` equals the source register, and the corresponding `id_use_rsN=1`.
- The result is registered into `fwd_sel_*` on advance.

**Load-use hazard**
- Condition: EX slot `is_load` and `rd` matches a used, nonzero rs of a valid ID instruction.
- Response: `pc_stall=ifid_stall=idex_bubble=1` for exactly one cycle; the EX slot becomes invalid.
- On the next cycle the load occupies MEM and forwarding yields 10.

**Branch flush**
- `ex_branch_taken=1` → `ifid_flush=idex_bubble=1`; the EX slot is loaded invalid.
- This overrides a load-use stall in the same cycle: no stall, and `ld_stall_cnt` does not increment.

**Freeze**
- `mem_busy=1` → `freeze=pc_stall=ifid_stall=1`, and `idex_bubble=ifid_flush=0`.
- Slots, `fwd_sel_*` and state hold.
- `ex_branch_taken` and load-use detection are ignored while `mem_busy=1`.

**Priority:** rst > mem_busy > ex_branch_taken > load-use.

**FSM** (state: `RUN`, `LD_STALL`, `MEM_WAIT`)
- `RUN` → `MEM_WAIT` on `mem_busy`; → `LD_STALL` on load-use.
- `LD_STALL` → `RUN` after one cycle. If `mem_busy` is high in `LD_STALL`, the FSM goes to `MEM_WAIT`, the stall outputs still apply, and the load-use re-evaluates in `RUN`.
- `MEM_WAIT` → `RUN` on the first cycle with `mem_busy=0`.

**Counters**
- Increment by 1 per cycle of load-use stall, branch flush, or `mem_busy` respectively.
- Saturate at all-ones.

## Timing

- Reset (synchronous):
  - all slots invalid; state `RUN`; counters 0; `fwd_sel_a=fwd_sel_b=00`;
  - `pc_stall`, `ifid_stall`, `idex_bubble`, `ifid_flush` and `freeze` are all 0 in the reset cycle and the cycle after.
- Control outputs (`pc_stall`, `ifid_stall`, `idex_bubble`, `ifid_flush`, `freeze`) are combinational from the current slots, state and inputs, with zero latency.
- `fwd_sel_*` are registered: set at the edge where the ID instruction enters EX, so they are valid for the instruction's whole EX residency. On a bubble they load 00.
- Reset asserted mid-stall or mid-freeze aborts immediately; no residual stall follows reset.

## Structure

- Package `hazard_pkg`:
  - `fwd_sel_t` with constants `FWD_RF`, `FWD_EXMEM`, `FWD_MEMWB`, `FWD_RET`;
  - `hz_state_t` (`RUN`, `LD_STALL`, `MEM_WAIT`);
  - scoreboard slot struct.
- Sub-module `hazard_scoreboard`: the 3-slot shift register with advance/bubble/hold controls and a match-priority function output.
- Top level: FSM, control decode, counters.

## Test plan

- EX slot `add x5` (`reg_write`); ID reads rs1=x5 → next edge `fwd_sel_a=01`, no stall.
- `lw x6`, then ID reads rs2=x6 → one cycle of `pc_stall`/`ifid_stall`/`idex_bubble`, `ld_stall_cnt=1`; the following advance gives `fwd_sel_b=10`.
- EX `add x0` writing, ID reads x0 → `fwd_sel_a=00`. Writer of x7 in EX and an older writer of x7 in MEM → 01 (EX priority). Writer only in WB → 11.
- Load-use and `ex_branch_taken` in the same cycle → `ifid_flush=idex_bubble=1`, `pc_stall=0`, `flush_cnt=1`, `ld_stall_cnt=0`.
- `mem_busy` high for 3 cycles during a load-use → `freeze=1`, slots and `fwd_sel` held, `busy_cnt=3`. Then a 1-cycle load stall occurs, and the result forwards correctly afterwards.
- Preset `busy_cnt` to all-ones → stays saturated. `rst` asserted mid-`MEM_WAIT` → all outputs 0 next cycle, state `RUN`.
